// File: rtl/pc_gen_pkg.sv
// Shared core definitions for the fetch PC generator: datapath width, reset
// address and 2-bit branch counter encodings.
package pc_gen_pkg;

    localparam int          CORE_XLEN     = 32;
    localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Saturating step of a 2-bit counter toward taken / not-taken.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        r = ctr;
        if (taken) begin
            if (ctr != CTR_ST) r = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) r = ctr - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_gen_bht.sv
// Direct-mapped branch history / target table: one combinational read port
// for fetch, one write port for the resolving EX instruction.
module bht_btb
    import pc_gen_pkg::*;
#(
    parameter int XLEN    = CORE_XLEN,
    parameter int ENTRIES = 16,
    localparam int IDXW   = $clog2(ENTRIES),
    localparam int TAGW   = XLEN - IDXW - 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] rd_idx_i,
    input  logic [TAGW-1:0] rd_tag_i,
    output logic            rd_hit_o,
    output logic [1:0]      rd_ctr_o,
    output logic [XLEN-1:0] rd_target_o,
    input  logic            upd_en_i,
    input  logic            upd_is_jmp_i,
    input  logic            upd_taken_i,
    input  logic [IDXW-1:0] upd_idx_i,
    input  logic [TAGW-1:0] upd_tag_i,
    input  logic [XLEN-1:0] upd_target_i
);

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic            upd_hit;
    logic [1:0]      ctr_base;
    logic [1:0]      ctr_d;

    // Read returns stored contents only; a same-cycle write is not bypassed.
    assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_ctr_o    = ctr_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];

    // A branch that does not own the entry starts training from weakly-not-taken.
    assign upd_hit  = valid_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag_i);
    assign ctr_base = upd_hit ? ctr_q[upd_idx_i] : CTR_WNT;

    always_comb begin
        ctr_d = ctr_step(ctr_base, upd_taken_i);
        if (upd_is_jmp_i) ctr_d = CTR_ST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= ctr_d;
            if (upd_taken_i) begin
                valid_q[upd_idx_i]  <= 1'b1;
                tag_q[upd_idx_i]    <= upd_tag_i;
                target_q[upd_idx_i] <= upd_target_i;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC sequencer: chooses between mispredict redirect, stall hold and the
// predicted next address, and trains the predictor from EX resolutions.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter int              ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CORE_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_is_br,
    input  logic            ex_is_jmp,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic            flush_o
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q;

    logic [XLEN-1:0] ex_tgt;
    logic            ctl_valid;
    logic            actual_taken;
    logic            rd_hit;
    logic [1:0]      rd_ctr;
    logic [XLEN-1:0] rd_target;

    // Only branches and jumps count as resolutions; anything else on ex_valid is ignored.
    assign ex_tgt       = ex_target & ~XLEN'(3);
    assign ctl_valid    = ex_valid & (ex_is_br | ex_is_jmp);
    assign actual_taken = ex_is_jmp | (ex_is_br & ex_taken);
    assign flush_o      = ctl_valid &
                          ((actual_taken != ex_pred_taken) |
                           (actual_taken & ex_pred_taken & (ex_tgt != ex_pred_target)));

    bht_btb #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES)
    ) u_bht_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_idx_i     (pc_q[IDXW+1:2]),
        .rd_tag_i     (pc_q[XLEN-1:IDXW+2]),
        .rd_hit_o     (rd_hit),
        .rd_ctr_o     (rd_ctr),
        .rd_target_o  (rd_target),
        .upd_en_i     (ctl_valid),
        .upd_is_jmp_i (ex_is_jmp),
        .upd_taken_i  (actual_taken),
        .upd_idx_i    (ex_pc[IDXW+1:2]),
        .upd_tag_i    (ex_pc[XLEN-1:IDXW+2]),
        .upd_target_i (ex_tgt)
    );

    assign pred_taken_o  = rd_hit & rd_ctr[1];
    assign pred_target_o = pred_taken_o ? rd_target : pc_q + XLEN'(4);

    // The first cycle out of reset presents RESET_PC as valid before advancing.
    always_comb begin
        pc_d = pc_q;
        if (!pc_valid_q) begin
            pc_d = pc_q;
        end else if (flush_o) begin
            pc_d = actual_taken ? ex_tgt : ex_pc + XLEN'(4);
        end else if (!stall) begin
            pc_d = pred_target_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = pc_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic, all checked
// against a table-and-arithmetic model of the fetch/predict rules.
module tb_pc_gen;

    localparam int          XLEN     = 32;
    localparam int          ENTRIES  = 16;
    localparam int          IDXW     = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk, rst_n, stall;
    logic        ex_valid, ex_is_br, ex_is_jmp, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic [31:0] pc_o, pred_target_o;
    logic        pc_valid_o, pred_taken_o, flush_o;

    pc_gen #(.XLEN(XLEN), .ENTRIES(ENTRIES), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_is_jmp(ex_is_jmp),
        .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pred_taken_o(pred_taken_o),
        .pred_target_o(pred_target_o), .flush_o(flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_pv;
    bit          mv   [ENTRIES];
    logic [31:0] mtag [ENTRIES];
    logic [31:0] mtgt [ENTRIES];
    int          mctr [ENTRIES];

    logic [31:0] pcs [8] = '{32'h10, 32'h14, 32'h20, 32'h30, 32'h50, 32'h90, 32'h110, 32'h3C};

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(ENTRIES));
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        return mv[m_idx(pc)] && (mtag[m_idx(pc)] == (pc >> (IDXW + 2)));
    endfunction

    function automatic logic m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (mctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? mtgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic logic m_actual();
        return ex_is_jmp || (ex_is_br && ex_taken);
    endfunction

    function automatic logic m_flush();
        logic [31:0] t;
        t = ex_target & 32'hFFFF_FFFC;
        if (!(ex_valid && (ex_is_br || ex_is_jmp))) return 1'b0;
        return (m_actual() != ex_pred_taken) ||
               (m_actual() && ex_pred_taken && (t != ex_pred_target));
    endfunction

    function automatic void m_reset();
        m_pc = RESET_PC;
        m_pv = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            mv[i]   = 1'b0;
            mtag[i] = '0;
            mtgt[i] = '0;
            mctr[i] = 1;
        end
    endfunction

    // Advance one clock: model computes the next PC from pre-edge state, then
    // applies the predictor training after the edge.
    task automatic tick();
        logic [31:0] npc;
        int          i, base;
        if (!m_pv)            npc = m_pc;
        else if (m_flush())   npc = m_actual() ? (ex_target & 32'hFFFF_FFFC) : ex_pc + 32'd4;
        else if (stall)       npc = m_pc;
        else                  npc = m_pred_target(m_pc);
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else begin
            if (ex_valid && (ex_is_br || ex_is_jmp)) begin
                i = m_idx(ex_pc);
                if (ex_is_jmp) begin
                    mctr[i] = 3;
                end else begin
                    base    = m_hit(ex_pc) ? mctr[i] : 1;
                    mctr[i] = ex_taken ? ((base == 3) ? 3 : base + 1) : ((base == 0) ? 0 : base - 1);
                end
                if (m_actual()) begin
                    mv[i]   = 1'b1;
                    mtag[i] = ex_pc >> (IDXW + 2);
                    mtgt[i] = ex_target & 32'hFFFF_FFFC;
                end
            end
            m_pc = npc;
            m_pv = 1'b1;
        end
        #1;
    endtask

    task automatic set_ex(input logic v, input logic br, input logic jmp, input logic tk,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        ex_valid = v; ex_is_br = br; ex_is_jmp = jmp; ex_taken = tk;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic clear_ex();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] seq [3];
        seq = '{32'h0, 32'h4, 32'h8};
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (pc_o !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_o, RESET_PC); end
        n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pc_valid_o); end
        n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %b want 0", pred_taken_o); end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (pc_o !== seq[k]) begin n_fail++; $display("FAIL release_pc[%0d]: got %h want %h", k, pc_o, seq[k]); end
            n_checks++; if (pc_valid_o !== 1'b1) begin n_fail++; $display("FAIL release_valid[%0d]: got %b want 1", k, pc_valid_o); end
            n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL release_pred[%0d]: got %b want 0", k, pred_taken_o); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (pc_o !== 32'h8) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want 00000008", k, pc_o); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (pc_o !== 32'hC) begin n_fail++; $display("FAIL stall_release: got %h want 0000000c", pc_o); end
    endtask

    task automatic test_branch_flush();
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 1'b0, 32'h0);
        #1;
        n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b want 1", flush_o); end
        tick();
        clear_ex();
        n_checks++; if (pc_o !== 32'h40) begin n_fail++; $display("FAIL br_redirect: got %h want 00000040", pc_o); end
        // Not-taken mispredict at 0xC steers fetch back to 0x10.
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 1'b1, 32'h0);
        #1;
        tick();
        clear_ex();
        n_checks++; if (pc_o !== 32'h10) begin n_fail++; $display("FAIL refetch_pc: got %h want 00000010", pc_o); end
        n_checks++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL refetch_pred: got %b want 1", pred_taken_o); end
        n_checks++; if (pred_target_o !== 32'h40) begin n_fail++; $display("FAIL refetch_target: got %h want 00000040", pred_target_o); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 4; k++) begin
            set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h40, m_pred_taken(32'h10), m_pred_target(32'h10));
            #1;
            n_checks++; if (flush_o !== m_flush()) begin n_fail++; $display("FAIL sat_flush[%0d]: got %b want %b", k, flush_o, m_flush()); end
            tick();
        end
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 1'b0, 32'h0);
        #1;
        n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL sat_noflush: got %b want 0", flush_o); end
        tick();
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 1'b1, 32'h0);
        #1;
        tick();
        clear_ex();
        n_checks++; if (pc_o !== 32'h10) begin n_fail++; $display("FAIL sat_pc: got %h want 00000010", pc_o); end
        n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL sat_pred: got %b want 0", pred_taken_o); end
        n_checks++; if (pred_target_o !== 32'h14) begin n_fail++; $display("FAIL sat_target: got %h want 00000014", pred_target_o); end
    endtask

    task automatic test_flush_stall();
        stall = 1'b1;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h80, 1'b1, 32'h80);
        #1;
        n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL fs_flush: got %b want 1", flush_o); end
        tick();
        stall = 1'b0;
        clear_ex();
        n_checks++; if (pc_o !== 32'h24) begin n_fail++; $display("FAIL fs_pc: got %h want 00000024", pc_o); end
    endtask

    task automatic test_wrap();
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFFC, 1'b0, 32'h0);
        #1;
        tick();
        clear_ex();
        n_checks++; if (pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_jump: got %h want fffffffc", pc_o); end
        n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL wrap_pred: got %b want 0", pred_taken_o); end
        tick();
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 00000000", pc_o); end
    endtask

    task automatic test_ignore();
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h80, 1'b1, 32'h44);
        #1;
        n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL ignore_flush: got %b want 0", flush_o); end
        tick();
        clear_ex();
        n_checks++; if (pc_o !== 32'h4) begin n_fail++; $display("FAIL ignore_pc: got %h want 00000004", pc_o); end
    endtask

    task automatic test_reset_mid();
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h30, 32'h80, 1'b0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        m_reset();
        n_checks++; if (pc_o !== RESET_PC) begin n_fail++; $display("FAIL mid_reset_pc: got %h want %h", pc_o, RESET_PC); end
        n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", pc_valid_o); end
        tick();
        clear_ex();
        rst_n = 1'b1;
        tick();
        n_checks++; if (pc_o !== RESET_PC) begin n_fail++; $display("FAIL mid_release_pc: got %h want %h", pc_o, RESET_PC); end
        tick();
        n_checks++; if (pc_o !== 32'h4) begin n_fail++; $display("FAIL mid_advance_pc: got %h want 00000004", pc_o); end
        // 0x100 was trained before the reset; it must now miss.
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h204, 32'h100, 1'b0, 32'h0);
        #1;
        tick();
        clear_ex();
        n_checks++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL mid_jump_pc: got %h want 00000100", pc_o); end
        n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL mid_table_cleared: got %b want 0", pred_taken_o); end
    endtask

    task automatic test_random();
        int kind;
        logic [31:0] tgt;
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                kind = $urandom_range(0, 5);
                tgt  = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
                set_ex(1'b1, kind < 4, kind == 4, 1'($urandom_range(0, 1)),
                       pcs[$urandom_range(0, 7)], tgt, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) == 1) ? (tgt & 32'hFFFF_FFFC) : ($urandom_range(0, 127) << 2));
            end else begin
                clear_ex();
            end
            #1;
            n_checks++; if (flush_o !== m_flush()) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", c, flush_o, m_flush()); end
            n_checks++; if (pc_o !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", c, pc_o, m_pc); end
            n_checks++; if (pc_valid_o !== m_pv) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, pc_valid_o, m_pv); end
            n_checks++; if (pred_taken_o !== m_pred_taken(m_pc)) begin n_fail++; $display("FAIL rnd_pred[%0d]: got %b want %b", c, pred_taken_o, m_pred_taken(m_pc)); end
            n_checks++; if (pred_target_o !== m_pred_target(m_pc)) begin n_fail++; $display("FAIL rnd_target[%0d]: got %h want %h", c, pred_target_o, m_pred_target(m_pc)); end
            tick();
        end
        clear_ex();
        stall = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        clear_ex();
        test_reset();
        test_stall();
        test_branch_flush();
        test_saturate();
        test_flush_stall();
        test_wrap();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
